// File: rtl/subtractor_n_bit_serial.sv
// subtractor_n_bit_serial: bit-serial N-bit subtractor (operand1 - operand2), LSB first, one bit per clock.
//   clock/reset_n           : rising-edge clock, asynchronous active-low reset
//   start                   : request, accepted in IDLE or DONE; operands captured on that edge
//   operand1/operand2 [N]   : minuend / subtrahend
//   busy                    : high for the N cycles of an operation
//   done                    : one-cycle pulse when result/borrow become valid
//   result [N], borrow      : difference mod 2^N and unsigned borrow, held until the next accepted start
//   SUB_SATURATE_EN         : when defined, a borrowing result is floored to 0 (borrow still reports 1)
module subtractor_n_bit_serial #(
  parameter int N = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         start,
  input  logic [N-1:0] operand1,
  input  logic [N-1:0] operand2,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         borrow
);
  localparam int CW = $clog2(N);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;
  logic [N-1:0] a_sh, b_sh, diff;
  logic [N-2:0] acc;
  logic [CW-1:0] cnt;
  logic bin, d, bout, last, accept;
  assign d      = a_sh[0] ^ b_sh[0] ^ bin;
  assign bout   = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & bin);
  assign last   = cnt == CW'(N - 1);
  assign accept = start && state != BUSY;
  // acc keeps the N-1 partial bits; the full difference only exists on the final bit
  assign diff   = {d, acc};
  assign busy   = state == BUSY;
  assign done   = state == DONE;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = accept ? BUSY : (state == BUSY) ? (last ? DONE : BUSY) : IDLE;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      acc    <= '0;
      cnt    <= '0;
      bin    <= 1'b0;
      result <= '0;
      borrow <= 1'b0;
    end else if (accept) begin
      a_sh <= operand1;
      b_sh <= operand2;
      acc  <= '0;
      cnt  <= '0;
      bin  <= 1'b0;
    end else if (state == BUSY) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      acc  <= diff[N-1:1];
      cnt  <= cnt + CW'(1);
      bin  <= bout;
      if (last) begin
`ifdef SUB_SATURATE_EN
        result <= bout ? '0 : diff;
`else
        result <= diff;
`endif
        borrow <= bout;
      end
    end
  end
endmodule

// File: doc/subtractor_n_bit_serial.md
Name: subtractor_N_bit_serial

Overview:
- Bit-serial N-bit subtractor computing operand1 - operand2, LSB first, one bit per clock.
- Shares the operand/result interface style of the team's registered N-bit adder, which it complements.
- Start/busy/done handshake lets a controller issue one subtraction at a time.
- Trades latency (N cycles) for a single-bit datapath. Sits beside the adder in the arithmetic block set.

Parameters:
- N, 4, operand and result width in bits; legal range N >= 2.

Ports:
- clock  input  1  single clock, all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled on rising edge, accepted only in IDLE or DONE
- operand1  input  N  minuend; captured on the accepting edge only
- operand2  input  N  subtrahend; captured on the accepting edge only
- busy  output  1  high while a subtraction is in progress (state BUSY)
- done  output  1  one-cycle pulse, high in state DONE
- result  output  N  difference modulo 2^N; held stable from DONE until the next accepted start
- borrow  output  1  1 when operand1 < operand2 (unsigned); valid and held with result

Behaviour:
- Reset (async, reset_n=0): state=IDLE. busy=0, done=0, result=0, borrow=0. Internal shift registers, borrow flop and bit counter are all cleared.
- Reset mid-operation: the operation is abandoned immediately; outputs take their reset values. After release, no done pulse occurs for the aborted operation.
- States:
  - IDLE: start=1 -> capture operand1, operand2 into shift registers; clear borrow flop and counter; go to BUSY.
  - BUSY: each edge:
    - d = a0 ^ b0 ^ bin
    - bout = (~a0 & b0) | (~(a0 ^ b0) & bin)
    - Shift d into the result register MSB-side; shift both operands right; counter++.
    - On the edge where counter reaches N-1 (the Nth bit), go to DONE and register the final bout as borrow.
  - DONE: done=1 for exactly one cycle. start=1 -> accept new operands, go to BUSY (back-to-back, no IDLE cycle). Else -> IDLE.
- Latency: accept on edge k; done=1 and result/borrow valid after edge k+N; done deasserts after edge k+N+1 unless restarted.
- busy=1 exactly N cycles per operation; busy and done are never both high.
- start while BUSY: ignored; the operands are not sampled and the operation in progress is unaffected.
- result is updated only on the DONE transition. Partial bits are kept in an internal register, so result never shows intermediate values.
- Wrap-around: arithmetic is modulo 2^N, e.g. 0 - 1 = 2^N - 1 with borrow=1.
- Counter width $clog2(N); no other width growth.

Optional Feature:
- Macro SUB_SATURATE_EN.
- Defined: when the final borrow is 1, result is forced to 0 on the DONE transition (unsigned floor saturation); borrow still reports 1.
- Undefined: result is the raw modulo-2^N difference.
- Timing and handshake are identical in both builds.

Test Plan:
- N=4, reset then start with 5,3 -> busy for 4 cycles, then done pulse; result=2, borrow=0; result still 2 three cycles later.
- 3,5 -> result=14 (4'b1110), borrow=1. With SUB_SATURATE_EN defined: result=0, borrow=1.
- 15,15 -> result=0, borrow=0; then 0,1 -> result=15, borrow=1 (wrap).
- Start with 9,4, then hold start=1 with operands 1,1 for two cycles during BUSY -> result=5 only, a single done pulse. Then start asserted in the DONE cycle with 7,2 -> busy the next cycle, result=5 after 4 more cycles.
- Start 12,3, drop reset_n after 2 busy cycles -> busy=0, done=0, result=0, borrow=0 immediately. No done pulse after release. A fresh 12,3 then gives result=9.
- Reset state check: with reset_n=0, all outputs are 0 regardless of start or clock.
